// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the MIPS pipeline: owns HI/LO, runs mult/div
// for a fixed latency and requests an ID stall for MD instructions while busy.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      opnd_a;
  logic [31:0]      opnd_b;
  logic [3:0]       op_q;

  logic        go;
  logic        is_long;
  logic        is_mul_q;
  logic        div_zero;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_long = (op >= OP_MULT) && (op <= OP_DIVU);
  assign go      = start & ~cancel & (state == IDLE);
  assign stall   = id_is_md & (busy | (start & ~cancel & is_long));

  always_comb begin
    rdata = 32'd0;
    if (op == OP_MFHI)      rdata = hi;
    else if (op == OP_MFLO) rdata = lo;
  end

  // Result datapath from the latched operands; signed divide works on magnitudes
  // so that 0x80000000 / -1 needs no special case.
  always_comb begin
    is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
    div_zero = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (opnd_b == 32'd0);
    ext_a    = {{32{opnd_a[31] & (op_q == OP_MULT)}}, opnd_a};
    ext_b    = {{32{opnd_b[31] & (op_q == OP_MULT)}}, opnd_b};
    prod     = ext_a * ext_b;
    a_neg    = opnd_a[31] & (op_q == OP_DIV);
    b_neg    = opnd_b[31] & (op_q == OP_DIV);
    a_mag    = a_neg ? (-opnd_a) : opnd_a;
    b_mag    = b_neg ? (-opnd_b) : opnd_b;
    q_mag    = 32'd0;
    r_mag    = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    if (is_mul_q) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_lo = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
      res_hi = a_neg ? (-r_mag) : r_mag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opnd_a <= 32'd0;
      opnd_b <= 32'd0;
      op_q   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go && is_long) begin
            opnd_a <= rs_val;
            opnd_b <= rt_val;
            op_q   <= op;
            cnt    <= ((op == OP_MULT) || (op == OP_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                            : CNT_W'(DIV_CYCLES);
            busy   <= 1'b1;
            state  <= BUSY;
          end else if (go && (op == OP_MTHI)) begin
            hi <= rs_val;
          end else if (go && (op == OP_MTLO)) begin
            lo <= rs_val;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            if (!div_zero) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
Sequences the multiply/divide unit of the pipelined MIPS core. It accepts HI/LO-class instructions from the EX stage, runs mult/div for a fixed multi-cycle latency, and owns the HI and LO registers. It also raises a stall request so that any MD instruction in ID is held until the unit is free. A cancel input squashes a start issued in the same cycle as an exception or interrupt flush.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
op  input  4  EX-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
start  input  1  EX-stage instruction is valid and op is meaningful this cycle
cancel  input  1  flush of EX this cycle; qualifies start
rs_val  input  32  forwarded rs operand in EX
rt_val  input  32  forwarded rt operand in EX
id_is_md  input  1  ID-stage instruction is any MD op (mult..mflo)
busy  output  1  multi-cycle operation in progress
stall  output  1  stall request to ID; ORed with the hazard stall
hi  output  32  HI register
lo  output  32  LO register
rdata  output  32  mfhi/mflo read data for EX

Behaviour:
- reset low, asynchronous: state IDLE, busy=0, counter=0, hi=0, lo=0, operand and result latches=0. Effect is immediate, including mid-operation; the in-flight result is discarded.
- go = start & ~cancel & (state==IDLE). A start while BUSY is ignored; stall makes this unreachable and the bench asserts it never occurs.
- States: IDLE and BUSY.
- IDLE -> BUSY on a clock edge with go and op in 1..4:
  - latch rs_val and rt_val;
  - compute the result into an internal latch;
  - counter := MULT_CYCLES for op 1/2, DIV_CYCLES for op 3/4.
- BUSY: counter decrements each edge. On the edge where counter==1, write HI/LO from the result latch, go to IDLE, and clear busy.
- Timing: if start is sampled at edge E0, busy=1 for exactly N cycles after E0, and new hi/lo become visible immediately after edge E_N.
- cancel while BUSY has no effect. The running op is architecturally committed; cancel only qualifies a same-cycle start.
- mult: {hi,lo} = signed 64-bit product of rs_val and rt_val. multu: unsigned product.
- div: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend. divu: unsigned quotient and remainder.
- Divisor 0: busy still runs DIV_CYCLES; hi/lo keep their prior values.
- Signed div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo (op 5/6) with go: hi (or lo) := rs_val at that edge, single cycle, no BUSY. Blocked with no effect when cancel=1 or state==BUSY.
- rdata is combinational: op==7 gives hi, op==8 gives lo, otherwise 0. In the same cycle as an mthi/mtlo write, rdata returns the old value.
- stall = id_is_md & (busy | (start & ~cancel & op in 1..4)). This is combinational and already covers the issue cycle.
- Non-MD instructions never stall here and flow past a busy unit.

Test Plan:
- Reset check: hold reset low mid-div (counter=6) -> busy=0, hi=lo=0 immediately. Release reset, then issue mult 3,4 -> lo=12 after 5 busy cycles.
- Signed and unsigned multiply:
  - mult rs=0xFFFFFFFD, rt=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFA.
- Signed and unsigned divide:
  - div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7,2 -> lo=3, hi=1.
  - div by 0 -> hi/lo unchanged after 10 cycles.
- Stall window: mult issued with id_is_md=1 -> stall=1 in the issue cycle plus 5 busy cycles, then 0. With id_is_md=0 -> stall=0 throughout.
- Cancel:
  - start=1 with cancel=1 on div -> busy stays 0, hi/lo unchanged, stall=0.
  - cancel pulsed during BUSY -> result still written at E_N.
- mthi/mtlo and reads: mthi 0x12345678 then mfhi next cycle -> rdata=0x12345678. mtlo while busy -> ignored, lo = mult result.
